s2fifo_pack: RTL

Stream-to-FIFO packer for the S2MM write path, the mirror of the MM2S FIFO-to-stream stage. It accepts a pixel AXI-Stream video input (tuser = SOF, tlast = EOL) and packs `C_ADATA_PIXELS` pixels into one memory word. It pushes each word with SOF/EOL side bits into the S2MM data FIFO that the AXI write master drains. It also checks frame geometry, resynchronises on SOF, and supports soft reset.

---
 rtl/s2fifo_pack_pkg.sv | 28 ++
 rtl/s2fifo_pack_if.sv | 27 ++
 rtl/s2fifo_pack_pix_lane_pack.sv | 54 +++++
 rtl/s2fifo_pack.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/s2fifo_pack_pkg.sv
// rtl/s2fifo_pack_pkg.sv - shared S2MM/MM2S packing definitions
package s2fifo_pack_pkg;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } state_e;

  // Pixels carried by one memory word.
  function automatic int adata_pixels(input int data_width, input int store_width);
    return data_width / store_width;
  endfunction

  // Sideband bit positions above the pixel field of a FIFO word.
  function automatic int sof_bit_idx(input int data_width);
    return data_width;
  endfunction

  function automatic int eol_bit_idx(input int data_width);
    return data_width + 1;
  endfunction

  // First pixel of a word lives in the most significant lane.
  function automatic int lane_index(input int n_pixels, input int k);
    return n_pixels - 1 - k;
  endfunction

endpackage

// File: rtl/s2fifo_pack_if.sv
// rtl/s2fifo_pack_if.sv - pixel stream input and S2MM data FIFO write port
interface s2fifo_pack_if #(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_DATA_WIDTH  = 32
);
  import s2fifo_pack_pkg::*;

  logic                               s_axis_tvalid;
  logic                               s_axis_tready;
  logic [C_PIXEL_WIDTH-1:0]           s_axis_tdata;
  logic                               s_axis_tuser;
  logic                               s_axis_tlast;
  logic                               fifo_full;
  logic                               fifo_wr_en;
  logic [eol_bit_idx(C_DATA_WIDTH):0] fifo_wr_data;

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tuser, s_axis_tlast, fifo_full,
    input  s_axis_tready, fifo_wr_en, fifo_wr_data
  );

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tuser, s_axis_tlast, fifo_full,
    output s_axis_tready, fifo_wr_en, fifo_wr_data
  );

endinterface

// File: rtl/s2fifo_pack_pix_lane_pack.sv
// rtl/s2fifo_pack_pix_lane_pack.sv - lane placement register for one memory word
module pix_lane_pack
  import s2fifo_pack_pkg::*;
#(
  parameter int C_PIXEL_WIDTH       = 8,
  parameter int C_PIXEL_STORE_WIDTH = 8,
  parameter int C_DATA_WIDTH        = 32,
  parameter int LANE_BITS           = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pix_valid,
  input  logic [LANE_BITS-1:0]     pix_lane,
  input  logic [C_PIXEL_WIDTH-1:0] pix_data,
  input  logic                     flush,     // drop old contents before placing this pixel
  input  logic                     clear,     // word handed off; start next word empty
  output logic [C_DATA_WIDTH-1:0]  acc,       // lanes gathered so far
  output logic [C_DATA_WIDTH-1:0]  word       // lanes including this cycle's pixel
);

  localparam int N = adata_pixels(C_DATA_WIDTH, C_PIXEL_STORE_WIDTH);

  logic [C_DATA_WIDTH-1:0]        acc_q, acc_d;
  logic [C_DATA_WIDTH-1:0]        merged;
  logic [C_PIXEL_STORE_WIDTH-1:0] lane_val;

  // Place the incoming pixel in its lane; unfilled lanes stay zero because every word starts cleared.
  always_comb begin
    lane_val                    = '0;
    lane_val[C_PIXEL_WIDTH-1:0] = pix_data;
    merged                      = flush ? '0 : acc_q;
    if (pix_valid) begin
      for (int k = 0; k < N; k++) begin
        if (k == int'(pix_lane)) begin
          merged[lane_index(N, k)*C_PIXEL_STORE_WIDTH +: C_PIXEL_STORE_WIDTH] = lane_val;
        end
      end
    end
    acc_d = clear ? '0 : merged;
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc  = acc_q;
  assign word = merged;

endmodule

// File: rtl/s2fifo_pack.sv
// rtl/s2fifo_pack.sv - pixel stream to S2MM data FIFO packer with frame checking
module s2fifo_pack
  import s2fifo_pack_pkg::*;
#(
  parameter int C_PIXEL_WIDTH       = 8,
  parameter int C_PIXEL_STORE_WIDTH = 8,
  parameter int C_IMG_WBITS         = 12,
  parameter int C_IMG_HBITS         = 12,
  parameter int C_DATA_WIDTH        = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   soft_resetn,
  output logic                   resetting,
  input  logic [C_IMG_WBITS-1:0] img_width,
  input  logic [C_IMG_HBITS-1:0] img_height,
  s2fifo_pack_if.slave           s_if,
  output logic                   w_sof,
  output logic                   frame_done,
  output logic                   frame_err
);

  localparam int C_ADATA_PIXELS = adata_pixels(C_DATA_WIDTH, C_PIXEL_STORE_WIDTH);
  localparam int LW             = (C_ADATA_PIXELS > 1) ? $clog2(C_ADATA_PIXELS) : 1;
  localparam logic [LW-1:0]          LANE_MAX = LW'(C_ADATA_PIXELS - 1);
  localparam logic [LW-1:0]          LANE_ONE = 1;
  localparam logic [C_IMG_WBITS-1:0] COL_ONE  = 1;
  localparam logic [C_IMG_HBITS-1:0] ROW_ONE  = 1;

  state_e                    state_q, state_d;
  logic [LW-1:0]             lane_q, lane_d;
  logic [C_IMG_WBITS-1:0]    col_q, col_d, width_q, width_d;
  logic [C_IMG_HBITS-1:0]    row_q, row_d, height_q, height_d;
  logic                      first_q, first_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_last_q, out_last_d;
  logic [C_DATA_WIDTH+1:0]   out_data_q, out_data_d;
  logic                      w_sof_q, w_sof_d;
  logic                      frame_err_q, frame_err_d;

  logic                      wr_en, can_load, restart_flush, tready, beat, start, take;
  logic [LW-1:0]             lane_e;
  logic [C_IMG_WBITS-1:0]    col_e, width_e;
  logic [C_IMG_HBITS-1:0]    row_e, height_e;
  logic                      first_e, col_last, eol, complete, frame_end;
  logic                      pk_valid, pk_flush, pk_clear;
  logic [C_DATA_WIDTH-1:0]   pk_acc, pk_word;

  pix_lane_pack #(
    .C_PIXEL_WIDTH      (C_PIXEL_WIDTH),
    .C_PIXEL_STORE_WIDTH(C_PIXEL_STORE_WIDTH),
    .C_DATA_WIDTH       (C_DATA_WIDTH),
    .LANE_BITS          (LW)
  ) u_pack (
    .clk      (clk),
    .reset    (reset),
    .pix_valid(pk_valid),
    .pix_lane (lane_e),
    .pix_data (s_if.s_axis_tdata),
    .flush    (pk_flush),
    .clear    (pk_clear),
    .acc      (pk_acc),
    .word     (pk_word)
  );

  // Handshake qualification and the beat's effective position (a starting beat counts as row 0, col 0).
  always_comb begin
    wr_en    = out_valid_q & ~s_if.fifo_full;
    can_load = ~out_valid_q | ~s_if.fifo_full;
    // A mid-frame SOF with a partial word pending costs one stalled cycle to flush that word first.
    restart_flush = (state_q == RUN) & s_if.s_axis_tvalid & s_if.s_axis_tuser & (lane_q != '0);
    // Any accepted beat may complete a word, so input also waits while the output register is stuck.
    tready   = soft_resetn & can_load & ~restart_flush;
    beat     = s_if.s_axis_tvalid & tready;
    start    = beat & s_if.s_axis_tuser;
    take     = beat & ((state_q == RUN) | s_if.s_axis_tuser);
    lane_e   = start ? '0 : lane_q;
    col_e    = start ? '0 : col_q;
    row_e    = start ? '0 : row_q;
    width_e  = start ? img_width  : width_q;
    height_e = start ? img_height : height_q;
    first_e  = start | first_q;
    col_last  = (col_e == width_e - COL_ONE);
    eol       = col_last | s_if.s_axis_tlast;
    complete  = (lane_e == LANE_MAX) | eol;
    frame_end = eol & (row_e == height_e - ROW_ONE);
  end

  // Next-state, counters, output register load and status pulses.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    col_d       = col_q;
    row_d       = row_q;
    width_d     = width_q;
    height_d    = height_q;
    first_d     = first_q;
    out_valid_d = out_valid_q & ~wr_en;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    w_sof_d     = 1'b0;
    frame_err_d = 1'b0;
    pk_valid    = 1'b0;
    pk_flush    = 1'b0;
    pk_clear    = 1'b0;

    if (!soft_resetn) begin
      // Partial word is discarded; a word already in the output register still drains.
      state_d  = WAIT_SOF;
      lane_d   = '0;
      col_d    = '0;
      row_d    = '0;
      first_d  = 1'b0;
      pk_clear = 1'b1;
    end else if (restart_flush && can_load) begin
      out_valid_d = 1'b1;
      out_data_d  = {1'b1, first_q, pk_acc};
      out_last_d  = 1'b0;
      frame_err_d = 1'b1;
      state_d     = WAIT_SOF;
      lane_d      = '0;
      col_d       = '0;
      row_d       = '0;
      first_d     = 1'b0;
      pk_clear    = 1'b1;
    end else if (take) begin
      pk_valid = 1'b1;
      pk_flush = start;
      pk_clear = complete;
      if (start) begin
        width_d  = img_width;
        height_d = img_height;
        w_sof_d  = 1'b1;
        state_d  = RUN;
        if (state_q == RUN) frame_err_d = 1'b1;
      end
      if (col_last != s_if.s_axis_tlast) frame_err_d = 1'b1;
      if (complete) begin
        out_valid_d = 1'b1;
        out_data_d  = {eol, first_e, pk_word};
        out_last_d  = frame_end;
        first_d     = 1'b0;
        lane_d      = '0;
      end else begin
        first_d = first_e;
        lane_d  = lane_e + LANE_ONE;
      end
      if (eol) begin
        col_d = '0;
        if (frame_end) begin
          row_d   = '0;
          state_d = WAIT_SOF;
        end else begin
          row_d = row_e + ROW_ONE;
        end
      end else begin
        col_d = col_e + COL_ONE;
        row_d = row_e;
      end
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_SOF;
      lane_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      width_q     <= '0;
      height_q    <= '0;
      first_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      w_sof_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      col_q       <= col_d;
      row_q       <= row_d;
      width_q     <= width_d;
      height_q    <= height_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      w_sof_q     <= w_sof_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign s_if.s_axis_tready = tready;
  assign s_if.fifo_wr_en    = wr_en;
  assign s_if.fifo_wr_data  = out_data_q;
  assign resetting          = ~soft_resetn & out_valid_q;
  assign w_sof              = w_sof_q;
  assign frame_err          = frame_err_q;
  assign frame_done         = wr_en & out_last_q;

endmodule
